voice_mixer: RTL and testbench

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer_pkg.sv | 20 ++
 rtl/mix_saturate.sv | 31 +++
 rtl/voice_mixer.sv | 92 +++++++++
 tb/tb_voice_mixer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/voice_mixer_pkg.sv
// Shared types and constants for the voice mixer: FSM state encoding,
// default geometry and the accumulator width derivation.
package voice_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  localparam int DEF_NUM_VOICES = 8;
  localparam int DEF_SAMPLE_W   = 16;

  // Enough headroom that summing num_voices full-scale samples never wraps.
  function automatic int acc_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices);
  endfunction

endpackage

// File: rtl/mix_saturate.sv
// Converts the wide mix accumulator to an output sample. With
// VOICE_MIXER_SAT_EN defined the sum is clamped; otherwise it is averaged.
module mix_saturate
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int ACC_W      = acc_width(DEF_SAMPLE_W, DEF_NUM_VOICES)
) (
  input  logic [ACC_W-1:0]    acc,
  output logic [SAMPLE_W-1:0] sample
);

`ifdef VOICE_MIXER_SAT_EN
  localparam logic signed [ACC_W-1:0] MAX_VAL =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_VAL = ~MAX_VAL;

  always_comb begin
    sample = acc[SAMPLE_W-1:0];
    if ($signed(acc) > MAX_VAL)      sample = MAX_VAL[SAMPLE_W-1:0];
    else if ($signed(acc) < MIN_VAL) sample = MIN_VAL[SAMPLE_W-1:0];
  end
`else
  localparam int SHIFT = $clog2(NUM_VOICES);

  // Arithmetic shift right by log2(N) is exactly the top SAMPLE_W bits.
  assign sample = acc[ACC_W-1:SHIFT];
`endif

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer: on each sample_tick fetches NUM_VOICES samples, sums them and
// presents the mix on a valid/ready output. Output conversion depends on VOICE_MIXER_SAT_EN.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int SAMPLE_W   = DEF_SAMPLE_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  output logic                          voice_rd,
  output logic [$clog2(NUM_VOICES)-1:0] voice_idx,
  input  logic [SAMPLE_W-1:0]           voice_sample,
  output logic [SAMPLE_W-1:0]           out_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = acc_width(SAMPLE_W, NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] cnt;
  logic             add_en;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [SAMPLE_W-1:0] mix_out;
  logic             handshake;
  logic             last_idx;

  assign handshake = out_valid & out_ready;
  assign last_idx  = (cnt == LAST_IDX);
  assign voice_rd  = (state == FETCH);
  assign voice_idx = voice_rd ? cnt : '0;

  // Samples arrive one cycle after their index, so the final add lands in DRAIN.
  assign acc_sum = acc + {{(ACC_W-SAMPLE_W){voice_sample[SAMPLE_W-1]}}, voice_sample};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:  if (sample_tick) state_next = FETCH;
      FETCH: if (last_idx)    state_next = DRAIN;
      DRAIN:                  state_next = OUT;
      OUT:   if (handshake)   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      add_en     <= 1'b0;
      acc        <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state  <= state_next;
      add_en <= voice_rd;
      cnt    <= (voice_rd && !last_idx) ? cnt + 1'b1 : '0;

      if (state == IDLE && sample_tick) acc <= '0;
      else if (add_en)                  acc <= acc_sum;

      if (state == DRAIN) begin
        out_sample <= mix_out;
        out_valid  <= 1'b1;
      end else if (handshake) begin
        out_valid  <= 1'b0;
      end

      if (sample_tick && state != IDLE) overrun <= 1'b1;
    end
  end

  mix_saturate #(
    .NUM_VOICES(NUM_VOICES),
    .SAMPLE_W  (SAMPLE_W),
    .ACC_W     (ACC_W)
  ) u_mix_saturate (
    .acc   (acc_sum),
    .sample(mix_out)
  );

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed and random passes compared
// against a plain-arithmetic model of the mix (sum, then clamp or floor-average).
module tb_voice_mixer;

  localparam int N  = 8;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick = 1'b0;
  logic          voice_rd;
  logic [2:0]    voice_idx;
  logic [SW-1:0] voice_sample = '0;
  logic [SW-1:0] out_sample;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          overrun;

  int errors = 0;
  int checks = 0;
  int voices [N];

  voice_mixer #(.NUM_VOICES(N), .SAMPLE_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .voice_rd    (voice_rd),
    .voice_idx   (voice_idx),
    .voice_sample(voice_sample),
    .out_sample  (out_sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Voice memory responder: answers each request one cycle later, garbage otherwise.
  initial begin
    bit rd;
    int idx;
    forever begin
      @(negedge clk);
      rd  = voice_rd;
      idx = int'(voice_idx);
      @(posedge clk);
      #1;
      voice_sample = rd ? SW'(voices[idx]) : SW'($urandom);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_out();
    int sum = 0;
    for (int i = 0; i < N; i++) sum += voices[i];
`ifdef VOICE_MIXER_SAT_EN
    if (sum > 32767)  return 32767;
    if (sum < -32768) return -32768;
    return sum;
`else
    if (sum >= 0) return sum / N;
    return -((-sum + N - 1) / N);
`endif
  endfunction

  function automatic int out_s();
    return int'($signed(out_sample));
  endfunction

  // One mix pass; hold>0 keeps out_ready low that many cycles after valid,
  // with a stray tick inserted during the hold when tick_at>=0.
  task automatic run_pass(input string tag, input int hold, input int tick_at);
    int exp, c, bad, stable_bad;
    exp = model_out();
    out_ready = (hold == 0);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    c = 1;
    bad = 0;
    while (!out_valid && c < N + 20) begin
      if (voice_rd !== (c <= N)) bad++;
      if (c <= N && int'(voice_idx) != c - 1) bad++;
      if (c > N && voice_idx !== 3'd0) bad++;
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_fetch_seq"}, bad, 0);
    check({tag, "_latency"}, c, N + 2);
    check({tag, "_sample"}, out_s(), exp);
    stable_bad = 0;
    for (int i = 0; i < hold; i++) begin
      sample_tick = (i == tick_at);
      @(posedge clk); #1;
      if (!out_valid || out_s() != exp) stable_bad++;
    end
    sample_tick = 1'b0;
    if (hold > 0) begin
      check({tag, "_hold_stable"}, stable_bad, 0);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) voices[i] = v;
  endtask

  initial begin
    int seen, c;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sample", out_s(), 0);
    check("rst_voice_rd", int'(voice_rd), 0);
    check("rst_voice_idx", int'(voice_idx), 0);
    check("rst_overrun", int'(overrun), 0);

    fill(1000);   run_pass("all1000", 0, -1);
    fill(32767);  run_pass("allmax", 0, -1);
    fill(-32768); run_pass("allmin", 0, -1);
    voices = '{100, -200, 300, -400, 500, -600, 700, -800};
    run_pass("alt", 0, -1);
    check("no_overrun", int'(overrun), 0);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) voices[i] = int'($signed(16'($urandom)));
      run_pass("rand", int'($urandom_range(0, 4)), -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    check("rand_no_overrun", int'(overrun), 0);

    // Backpressure with a dropped tick: no second pass may start.
    for (int i = 0; i < N; i++) voices[i] = int'($signed(16'($urandom)));
    run_pass("bp", 20, 7);
    check("bp_overrun", int'(overrun), 1);
    seen = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (voice_rd || out_valid) seen++;
      @(posedge clk); #1;
    end
    check("bp_no_extra_pass", seen, 0);
    fill(-3); run_pass("after_bp", 0, -1);
    check("overrun_sticky", int'(overrun), 1);

    // Reset wins over a simultaneous tick.
    reset = 1'b1; sample_tick = 1'b1;
    @(posedge clk); #1 reset = 1'b0; sample_tick = 1'b0;
    check("rst_prio_rd", int'(voice_rd), 0);
    check("rst_clears_overrun", int'(overrun), 0);

    // Reset mid-fetch, then a clean pass.
    fill(5000);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    c = 0;
    while (!(voice_rd && voice_idx == 3'd3) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    check("mid_reached_idx3", int'(voice_idx), 3);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("mid_rst_outs", int'({voice_rd, voice_idx, out_sample, out_valid, overrun}), 0);
    for (int i = 0; i < N; i++) voices[i] = 1000 * (i + 1) - 4000;
    run_pass("post_rst", 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
